// File: rtl/onchip_mem_pkg.sv
// Shared constants and types for the dual-port on-chip memory.
package onchip_mem_pkg;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    // Byte lanes per data word.
    function automatic int num_lanes(input int data_w);
        return data_w / 8;
    endfunction

    // Read latency in cycles: one for the array read, plus one for the optional output register.
    function automatic int rd_latency(input int outreg);
        return (outreg != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/onchip_dp_rd_pipe.sv
// Per-port read return path: valid shift register, write-through bypass merge,
// out-of-range zeroing and the optional output register.
module onchip_dp_rd_pipe
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OUTREG = 0
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           clken,
    input  logic                           rd_acc,
    input  logic                           rd_oor,
    input  logic [num_lanes(DATA_W)-1:0]   byp_be,
    input  logic [DATA_W-1:0]              byp_data,
    input  logic [DATA_W-1:0]              raw_data,
    output logic [DATA_W-1:0]              readdata,
    output logic                           readdatavalid
);

    localparam int NB     = num_lanes(DATA_W);
    localparam int STAGES = rd_latency(OUTREG);

    logic [STAGES:1]   vld_pipe_q, vld_pipe_d;
    logic              oor_q, oor_d;
    logic [NB-1:0]     byp_be_q, byp_be_d;
    logic [DATA_W-1:0] byp_data_q, byp_data_d;
    logic [DATA_W-1:0] merged;

    // Advance the valid pipe and capture bypass info alongside the array read; hold on stall.
    always_comb begin
        vld_pipe_d = vld_pipe_q;
        oor_d      = oor_q;
        byp_be_d   = byp_be_q;
        byp_data_d = byp_data_q;
        if (clken) begin
            vld_pipe_d[1] = rd_acc;
            for (int i = 2; i <= STAGES; i++) vld_pipe_d[i] = vld_pipe_q[i-1];
            if (rd_acc) begin
                oor_d      = rd_oor;
                byp_be_d   = byp_be;
                byp_data_d = byp_data;
            end
        end
    end

    // Pipeline state registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_pipe_q <= '0;
            oor_q      <= 1'b0;
            byp_be_q   <= '0;
            byp_data_q <= '0;
        end else begin
            vld_pipe_q <= vld_pipe_d;
            oor_q      <= oor_d;
            byp_be_q   <= byp_be_d;
            byp_data_q <= byp_data_d;
        end
    end

    // Lanes written by the other port in the read cycle override the stale array data.
    always_comb begin
        merged = raw_data;
        for (int l = 0; l < NB; l++)
            if (byp_be_q[l]) merged[l*8 +: 8] = byp_data_q[l*8 +: 8];
        if (oor_q) merged = '0;
    end

    if (OUTREG != 0) begin : g_outreg
        logic [DATA_W-1:0] dout_q, dout_d;

        // Output register loads only when stage 1 holds a live read, so it holds otherwise.
        always_comb begin
            dout_d = dout_q;
            if (clken && vld_pipe_q[1]) dout_d = merged;
        end

        // Output data register.
        always_ff @(posedge clk) begin
            if (!reset_n) dout_q <= '0;
            else          dout_q <= dout_d;
        end

        assign readdata = dout_q;
    end else begin : g_direct
        // Source registers only load on accepted reads, so this already holds between reads.
        assign readdata = merged;
    end

    assign readdatavalid = vld_pipe_q[STAGES];

endmodule

// File: rtl/onchip_dp_memory.sv
// True dual-port byte-enabled on-chip memory with a pipelined read return per port.
// Initial contents are attached from INIT_FILE by the device configuration flow.
module onchip_dp_memory
    import onchip_mem_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 64000,
    parameter int OUTREG    = 0,
    parameter     INIT_FILE = "onchip_dp_memory.hex"
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      clken,
    input  logic [ADDR_W-1:0]         address_a,
    input  logic                      chipselect_a,
    input  logic                      read_a,
    input  logic                      write_a,
    input  logic [DATA_W/8-1:0]       byteenable_a,
    input  logic [DATA_W-1:0]         writedata_a,
    input  logic [ADDR_W-1:0]         address_b,
    input  logic                      chipselect_b,
    input  logic                      read_b,
    input  logic                      write_b,
    input  logic [DATA_W/8-1:0]       byteenable_b,
    input  logic [DATA_W-1:0]         writedata_b,
    output logic [DATA_W-1:0]         readdata_a,
    output logic                      readdatavalid_a,
    output logic                      waitrequest_a,
    output logic [DATA_W-1:0]         readdata_b,
    output logic                      readdatavalid_b,
    output logic                      waitrequest_b
);

    localparam int NB = num_lanes(DATA_W);

    logic                    waitreq;
    logic [1:0][ADDR_W-1:0]  addr;
    logic [1:0]              cs, rd, wr;
    logic [1:0][NB-1:0]      be;
    logic [1:0][DATA_W-1:0]  wdata;
    logic [1:0]              in_range, wr_en, rd_acc, rd_en;
    logic [1:0][NB-1:0]      byp_be;
    logic [1:0][DATA_W-1:0]  byp_data;
    logic [1:0][DATA_W-1:0]  raw_q, raw_d;
    logic [1:0][DATA_W-1:0]  rdata;
    logic [1:0]              rvalid;

    logic [DATA_W-1:0] mem [DEPTH];

    assign waitreq       = ~clken | ~reset_n;
    assign waitrequest_a = waitreq;
    assign waitrequest_b = waitreq;

    assign addr[PORT_A]  = address_a;     assign addr[PORT_B]  = address_b;
    assign cs[PORT_A]    = chipselect_a;  assign cs[PORT_B]    = chipselect_b;
    assign rd[PORT_A]    = read_a;        assign rd[PORT_B]    = read_b;
    assign wr[PORT_A]    = write_a;       assign wr[PORT_B]    = write_b;
    assign be[PORT_A]    = byteenable_a;  assign be[PORT_B]    = byteenable_b;
    assign wdata[PORT_A] = writedata_a;   assign wdata[PORT_B] = writedata_b;

    // Command decode; a write on a port masks its own read.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            in_range[p] = (32'(addr[p]) < 32'(DEPTH));
            wr_en[p]    = cs[p] & wr[p] & ~waitreq & in_range[p];
            rd_acc[p]   = cs[p] & rd[p] & ~wr[p] & ~waitreq;
            rd_en[p]    = rd_acc[p] & in_range[p];
            byp_be[p]   = (wr_en[1-p] && addr[1-p] == addr[p]) ? be[1-p] : '0;
            byp_data[p] = wdata[1-p];
        end
    end

    // Byte-lane writes; port A is applied last so it wins lanes both ports enable.
    always_ff @(posedge clk) begin
        for (int l = 0; l < NB; l++) begin
            if (wr_en[PORT_B] && be[PORT_B][l])
                mem[addr[PORT_B]][l*8 +: 8] <= wdata[PORT_B][l*8 +: 8];
            if (wr_en[PORT_A] && be[PORT_A][l])
                mem[addr[PORT_A]][l*8 +: 8] <= wdata[PORT_A][l*8 +: 8];
        end
    end

    // Array read register; loads only for in-range accepted reads (pre-write contents).
    always_comb begin
        raw_d = raw_q;
        for (int p = 0; p < 2; p++)
            if (rd_en[p]) raw_d[p] = mem[addr[p]];
    end

    // Array read data registers.
    always_ff @(posedge clk) begin
        if (!reset_n) raw_q <= '0;
        else          raw_q <= raw_d;
    end

    for (genvar p = 0; p < 2; p++) begin : g_port
        onchip_dp_rd_pipe #(
            .DATA_W (DATA_W),
            .OUTREG (OUTREG)
        ) u_rd_pipe (
            .clk           (clk),
            .reset_n       (reset_n),
            .clken         (clken),
            .rd_acc        (rd_acc[p]),
            .rd_oor        (~in_range[p]),
            .byp_be        (byp_be[p]),
            .byp_data      (byp_data[p]),
            .raw_data      (raw_q[p]),
            .readdata      (rdata[p]),
            .readdatavalid (rvalid[p])
        );
    end

    assign readdata_a      = rdata[PORT_A];
    assign readdatavalid_a = rvalid[PORT_A];
    assign readdata_b      = rdata[PORT_B];
    assign readdatavalid_b = rvalid[PORT_B];

endmodule

// File: tb/tb_onchip_dp_memory.sv
// Directed bench: two instances (OUTREG=0 and OUTREG=1) driven with identical stimulus.
module tb_onchip_dp_memory;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clken = 1'b1;
    logic [15:0] address_a, address_b;
    logic        chipselect_a, read_a, write_a, chipselect_b, read_b, write_b;
    logic [3:0]  byteenable_a, byteenable_b;
    logic [31:0] writedata_a, writedata_b;

    logic [31:0] rdata0_a, rdata0_b, rdata1_a, rdata1_b;
    logic        rdv0_a, rdv0_b, rdv1_a, rdv1_b;
    logic        wrq0_a, wrq0_b, wrq1_a, wrq1_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    onchip_dp_memory #(.OUTREG(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .address_a(address_a), .chipselect_a(chipselect_a), .read_a(read_a), .write_a(write_a),
        .byteenable_a(byteenable_a), .writedata_a(writedata_a),
        .address_b(address_b), .chipselect_b(chipselect_b), .read_b(read_b), .write_b(write_b),
        .byteenable_b(byteenable_b), .writedata_b(writedata_b),
        .readdata_a(rdata0_a), .readdatavalid_a(rdv0_a), .waitrequest_a(wrq0_a),
        .readdata_b(rdata0_b), .readdatavalid_b(rdv0_b), .waitrequest_b(wrq0_b)
    );

    onchip_dp_memory #(.OUTREG(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .clken(clken),
        .address_a(address_a), .chipselect_a(chipselect_a), .read_a(read_a), .write_a(write_a),
        .byteenable_a(byteenable_a), .writedata_a(writedata_a),
        .address_b(address_b), .chipselect_b(chipselect_b), .read_b(read_b), .write_b(write_b),
        .byteenable_b(byteenable_b), .writedata_b(writedata_b),
        .readdata_a(rdata1_a), .readdatavalid_a(rdv1_a), .waitrequest_a(wrq1_a),
        .readdata_b(rdata1_b), .readdatavalid_b(rdv1_b), .waitrequest_b(wrq1_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        chipselect_a = 1'b0; read_a = 1'b0; write_a = 1'b0; address_a = '0;
        byteenable_a = '0; writedata_a = '0;
        chipselect_b = 1'b0; read_b = 1'b0; write_b = 1'b0; address_b = '0;
        byteenable_b = '0; writedata_b = '0;
    endtask

    task automatic drv_a(input logic r, input logic w, input logic [15:0] ad,
                         input logic [31:0] d, input logic [3:0] be);
        chipselect_a = 1'b1; read_a = r; write_a = w; address_a = ad;
        writedata_a = d; byteenable_a = be;
    endtask

    task automatic drv_b(input logic r, input logic w, input logic [15:0] ad,
                         input logic [31:0] d, input logic [3:0] be);
        chipselect_b = 1'b1; read_b = r; write_b = w; address_b = ad;
        writedata_b = d; byteenable_b = be;
    endtask

    initial begin
        idle_all();
        reset_n = 1'b0;
        clken   = 1'b1;
        step();
        step();
        chk("rst_rdv0_a",   32'(rdv0_a), 32'd0);
        chk("rst_rdv1_b",   32'(rdv1_b), 32'd0);
        chk("rst_rdata1_a", rdata1_a, 32'd0);
        chk("rst_wait_a",   32'(wrq0_a), 32'd1);
        reset_n = 1'b1;
        #1;
        chk("rel_wait_b",   32'(wrq1_b), 32'd0);

        // write A then read B the next cycle
        drv_a(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
        step();
        idle_all();
        drv_b(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
        step();
        chk("wr_rd_v0",       32'(rdv0_b), 32'd1);
        chk("wr_rd_d0",       rdata0_b, 32'hDEADBEEF);
        chk("wr_rd_v1_early", 32'(rdv1_b), 32'd0);
        idle_all();
        step();
        chk("wr_rd_v0_once",  32'(rdv0_b), 32'd0);
        chk("wr_rd_hold0",    rdata0_b, 32'hDEADBEEF);
        chk("wr_rd_v1",       32'(rdv1_b), 32'd1);
        chk("wr_rd_d1",       rdata1_b, 32'hDEADBEEF);
        step();
        chk("wr_rd_v1_once",  32'(rdv1_b), 32'd0);

        // fill 0..2, then back-to-back reads on A
        drv_a(1'b0, 1'b1, 16'h0000, 32'h000000A0, 4'hF);
        drv_b(1'b0, 1'b1, 16'h0001, 32'h000000A1, 4'hF);
        step();
        idle_all();
        drv_a(1'b0, 1'b1, 16'h0002, 32'h000000A2, 4'hF);
        step();
        for (int i = 0; i < 5; i++) begin
            idle_all();
            if (i < 3) drv_a(1'b1, 1'b0, 16'(i), 32'h0, 4'h0);
            step();
            chk($sformatf("b2b_v1_%0d", i), 32'(rdv1_a), 32'(i >= 1 && i <= 3));
            if (i >= 1 && i <= 3) chk($sformatf("b2b_d1_%0d", i), rdata1_a, 32'hA0 + 32'(i - 1));
            chk($sformatf("b2b_v0_%0d", i), 32'(rdv0_a), 32'(i <= 2));
            if (i <= 2) chk($sformatf("b2b_d0_%0d", i), rdata0_a, 32'hA0 + 32'(i));
        end

        // read+write on one port: write wins, no valid
        drv_a(1'b1, 1'b1, 16'h0002, 32'h00000055, 4'hF);
        step();
        idle_all();
        chk("rw_novalid0", 32'(rdv0_a), 32'd0);
        step();
        chk("rw_novalid1", 32'(rdv1_a), 32'd0);

        // same-cycle dual write to one address
        drv_a(1'b0, 1'b1, 16'h0020, 32'h11111111, 4'h3);
        drv_b(1'b0, 1'b1, 16'h0020, 32'h22222222, 4'hF);
        step();
        idle_all();
        drv_a(1'b1, 1'b0, 16'h0020, 32'h0, 4'h0);
        step();
        idle_all();
        chk("dualwr_d", rdata0_a, 32'h22221111);

        // write-through bypass: A writes upper half while B reads
        drv_a(1'b0, 1'b1, 16'h0030, 32'h00000000, 4'hF);
        step();
        drv_a(1'b0, 1'b1, 16'h0030, 32'hCAFEF00D, 4'hC);
        drv_b(1'b1, 1'b0, 16'h0030, 32'h0, 4'h0);
        step();
        idle_all();
        chk("byp_v0", 32'(rdv0_b), 32'd1);
        chk("byp_d0", rdata0_b, 32'hCAFE0000);
        step();
        chk("byp_d1", rdata1_b, 32'hCAFE0000);
        drv_a(1'b1, 1'b0, 16'h0030, 32'h0, 4'h0);
        step();
        idle_all();
        chk("byp_stored", rdata0_a, 32'hCAFE0000);

        // out of range read / write, and byteenable=0 write
        drv_a(1'b1, 1'b0, 16'd64000, 32'h0, 4'h0);
        step();
        chk("oor_v0", 32'(rdv0_a), 32'd1);
        chk("oor_d0", rdata0_a, 32'h0);
        drv_a(1'b0, 1'b1, 16'd64000, 32'hFFFFFFFF, 4'hF);
        drv_b(1'b0, 1'b1, 16'h0001, 32'hFFFFFFFF, 4'h0);
        step();
        drv_a(1'b1, 1'b0, 16'h0000, 32'h0, 4'h0);
        drv_b(1'b1, 1'b0, 16'h0001, 32'h0, 4'h0);
        step();
        chk("oor_addr0", rdata0_a, 32'h000000A0);
        chk("be0_addr1", rdata0_b, 32'h000000A1);
        idle_all();
        drv_a(1'b1, 1'b0, 16'h0002, 32'h0, 4'h0);
        step();
        idle_all();
        chk("rw_written", rdata0_a, 32'h00000055);
        step();

        // clock-enable stall on an in-flight OUTREG=1 read
        drv_a(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
        step();
        idle_all();
        clken = 1'b0;
        drv_a(1'b0, 1'b1, 16'h0010, 32'h00000000, 4'hF);
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("stall_v1_%0d", k), 32'(rdv1_a), 32'd0);
            chk($sformatf("stall_wait_%0d", k), 32'(wrq1_a), 32'd1);
        end
        idle_all();
        clken = 1'b1;
        step();
        chk("stall_v1_late", 32'(rdv1_a), 32'd1);
        chk("stall_d1",      rdata1_a, 32'hDEADBEEF);
        step();
        chk("stall_v1_once", 32'(rdv1_a), 32'd0);

        // reset the cycle after a read: flushed, outputs cleared
        drv_a(1'b1, 1'b0, 16'h0030, 32'h0, 4'h0);
        step();
        idle_all();
        reset_n = 1'b0;
        step();
        chk("flush_v1",   32'(rdv1_a), 32'd0);
        chk("flush_d1",   rdata1_a, 32'h0);
        chk("flush_d0",   rdata0_a, 32'h0);
        chk("flush_v0",   32'(rdv0_a), 32'd0);
        chk("flush_wait", 32'(wrq0_a), 32'd1);
        reset_n = 1'b1;
        step();
        chk("flush_v1_a", 32'(rdv1_a), 32'd0);
        step();
        chk("flush_v1_b", 32'(rdv1_a), 32'd0);

        // memory survives reset and ignored the stalled write
        drv_a(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
        step();
        idle_all();
        chk("keep_d0", rdata0_a, 32'hDEADBEEF);
        step();
        chk("keep_d1", rdata1_a, 32'hDEADBEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
